// File: rtl/spi_controller_if.sv
// Request/response and pin bundle for spi_controller.
// master = requester side, slave = the controller itself.
interface spi_controller_if;
  logic       start;
  logic       write;
  logic [6:0] addr;
  logic [7:0] data;
  logic       ready;
  logic       done;
  logic       err;
  logic       nCS;
  logic       SCLK;
  logic       COPI;

  modport master (
    output start, write, addr, data,
    input  ready, done, err, nCS, SCLK, COPI
  );

  modport slave (
    input  start, write, addr, data,
    output ready, done, err, nCS, SCLK, COPI
  );
endinterface

// File: rtl/spi_controller.sv
// Mode-0, MSB-first SPI writer for 16-bit {write, addr, data} frames.
// Optional feature macro: SPI_CONTROLLER_ADDR_FILTER_EN (drop reads / out-of-map addresses).
module spi_controller #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input logic             i_clk,
  input logic             i_rst,
  spi_controller_if.slave bus
);

  if (CLK_DIV < 4) begin : g_bad_div
    $error("spi_controller: CLK_DIV must be >= 4");
  end

  localparam int unsigned CntMax = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'((CS_GAP == 0) ? 0 : CS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap, StReject} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [4:0]      r_rises, w_rises_d;
  logic [15:0]     r_shift, w_shift_d;
  logic            r_ncs, w_ncs_d;
  logic            r_sclk, w_sclk_d;
  logic            r_copi, w_copi_d;
  logic            r_ready, w_ready_d;
  logic            r_done, w_done_d;
  logic            r_err, w_err_d;

  logic       w_accept, w_drop, w_div_hit, w_gap_hit;
  logic [4:0] w_rises_inc;

  assign w_accept    = bus.start && r_ready;
  assign w_div_hit   = (r_cnt == DivLast);
  assign w_gap_hit   = (r_cnt == GapLast);
  assign w_rises_inc = (r_rises == 5'd16) ? 5'd16 : r_rises + 5'd1;

`ifdef SPI_CONTROLLER_ADDR_FILTER_EN
  assign w_drop = !bus.write || (bus.addr > 7'h04);
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rises <= '0;
      r_shift <= '0;
      r_ncs   <= 1'b1;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_rises <= w_rises_d;
      r_shift <= w_shift_d;
      r_ncs   <= w_ncs_d;
      r_sclk  <= w_sclk_d;
      r_copi  <= w_copi_d;
      r_ready <= w_ready_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_accept) w_state_d = w_drop ? StReject : StSetup;
      StSetup:  if (w_div_hit) w_state_d = StShift;
      StShift:  if (w_div_hit && r_sclk && (r_rises == 5'd16)) w_state_d = StHold;
      StHold:   if (w_div_hit) w_state_d = StGap;
      StGap:    if (w_gap_hit) w_state_d = StIdle;
      StReject: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d   = r_cnt + CntW'(1);
    w_rises_d = r_rises;
    w_shift_d = r_shift;
    w_ncs_d   = r_ncs;
    w_sclk_d  = r_sclk;
    w_copi_d  = r_copi;
    w_ready_d = r_ready;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;
    // Counter restarts on every state change and on every SCLK edge.
    if ((w_state_d != r_state) || (r_state == StIdle) || (r_state == StReject) ||
        ((r_state == StShift) && w_div_hit)) begin
      w_cnt_d = '0;
    end
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_ready_d = 1'b0;
          w_rises_d = '0;
          if (w_drop) begin
            w_err_d = 1'b1;
          end else begin
            w_shift_d = {bus.write, bus.addr, bus.data};
            w_ncs_d   = 1'b0;
            w_copi_d  = bus.write;
          end
        end
      end
      StSetup: begin
        if (w_div_hit) begin
          w_sclk_d  = 1'b1;
          w_rises_d = w_rises_inc;
        end
      end
      StShift: begin
        if (w_div_hit) begin
          w_sclk_d = !r_sclk;
          if (!r_sclk) begin
            w_rises_d = w_rises_inc;
          end else if (r_rises == 5'd16) begin
            w_copi_d = 1'b0;
          end else begin
            w_shift_d = {r_shift[14:0], 1'b0};
            w_copi_d  = r_shift[14];
          end
        end
      end
      StHold:   if (w_div_hit) w_ncs_d = 1'b1;
      StGap: begin
        if (w_gap_hit) begin
          w_done_d  = 1'b1;
          w_ready_d = 1'b1;
        end
      end
      StReject: w_ready_d = 1'b1;
      default:  w_ready_d = 1'b1;
    endcase
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.nCS   = r_ncs;
  assign bus.SCLK  = r_sclk;
  assign bus.COPI  = r_copi;

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI controller for the write-only register bus. It serialises one 16-bit frame per request onto nCS/SCLK/COPI using mode 0, MSB first. The frame format is {write, addr[6:0], data[7:0]}, matching the on-chip SPI peripheral's register map (0x00 to 0x04: out enables, PWM enables, duty cycle). It sits between test/config logic and the peripheral's pins, and paces SCLK slowly enough for a receiver that double-flop-synchronises every line on the same `clk`.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period. Must be ≥4; elaboration `$error` otherwise.
- `CS_GAP`, default 8: `clk` cycles nCS stays high after a frame before the next one may start.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted when `start && ready`.
- `write`  in  1  frame bit 15.
- `addr`  in  7  frame bits 14:8.
- `data`  in  8  frame bits 7:0.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse when a frame, including its gap, completes.
- `err`  out  1  one-cycle pulse on a filtered request (see Configuration).
- `nCS`  out  1  chip select, active low.
- `SCLK`  out  1  serial clock, idle low.
- `COPI`  out  1  serial data out.

## Operation
- All outputs are registered.
- Reset values: `nCS`=1, `SCLK`=0, `COPI`=0, `ready`=1, `done`=0, `err`=0, state IDLE, counters 0.
- On accept, `{write, addr, data}` is latched into a 16-bit shift register. Inputs are don't-care afterwards.
- States and transitions:
  - IDLE → SETUP on accept.
  - SETUP → SHIFT after CLK_DIV cycles.
  - SHIFT → HOLD after the 16th SCLK fall.
  - HOLD → GAP after CLK_DIV cycles.
  - GAP → IDLE after CS_GAP cycles.
- SETUP: `nCS`=0, `COPI`=bit15.
- SHIFT: `SCLK` toggles every CLK_DIV cycles.
  - The peripheral samples on each rise; this block counts rises (0..16).
  - `COPI` advances to the next bit on each fall, except after the 16th fall, when it is driven 0.
- HOLD: `nCS`=0, `SCLK`=0.
- GAP: `nCS`=1. `done` pulses on the GAP→IDLE cycle, together with `ready` rising.
- `start` while not ready is ignored. No queuing.
- `rst` mid-frame: the next edge forces all reset values. `nCS` goes high without completing the frame, and no `done` pulse is issued.
- The half-period counter and bit counter never wrap. The bit counter saturates at 16 and is cleared on accept.

## Timing
- Accept on cycle 0. Then:
  - `nCS` falls on cycle 1.
  - SCLK rise k (k=0..15) at cycle 1+CLK_DIV·(2k+1).
  - SCLK fall k at cycle 1+CLK_DIV·(2k+2).
  - `nCS` rises at cycle 1+33·CLK_DIV.
  - `done` and `ready` at cycle 1+33·CLK_DIV+CS_GAP.
- Defaults: `nCS` low on cycles 1..132, `done` at cycle 141. The earliest next accept is cycle 141, so the next `nCS` fall is at 142.
- `COPI` is stable for ≥CLK_DIV cycles on both sides of every SCLK rise.
- `ready` drops the cycle after accept.

## Configuration
- Macro `SPI_CONTROLLER_ADDR_FILTER_EN`.
- Defined:
  - A request with `write`=0, or with `addr` > 0x04, is still accepted via the handshake, but no frame is sent and `nCS` stays 1.
  - `err` pulses on cycle 1.
  - `ready` returns on cycle 2.
  - `done` is not pulsed.
- Undefined: every accepted request is transmitted verbatim, and `err` is tied 0.

## Test plan
- Reset, then write=1, addr=0x04, data=0xA5 with defaults → COPI at rises = 1000_0100_1010_0101; nCS low cycles 1..132; done at 141; a model peripheral's duty register reads 0xA5.
- Back-to-back requests (0x00/0xFF, then 0x01/0x0F) with start held high → second nCS fall at cycle 142; both registers are updated in the model.
- `start` pulsed at cycles 10 and 50 during a frame → ignored: exactly one frame, one done.
- `rst` asserted at cycle 60 of a frame → on the next edge nCS=1, SCLK=0, COPI=0, ready=1; no done; a new request afterwards transmits correctly.
- CLK_DIV=6, CS_GAP=2, addr=0x02, data=0x3C → rises at cycles 7, 19, …, 187; nCS rises at 199; done at 201.
- With `SPI_CONTROLLER_ADDR_FILTER_EN`: addr=0x05 → err at cycle 1, ready at cycle 2, nCS never falls. Without the macro: the same request produces a full frame and err stays 0.
